// File: rtl/pwm_phase_sequencer.sv
// PWM phase sequencer: turns Period/Duty into alternating high/low phases timed by a downstream
// Counter, with per-period shadowing so mid-period setting changes never glitch PwmOut.
module pwm_phase_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MIN_PHASE = 3
) (
    input  logic             MClk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic [WIDTH-1:0] Period,
    input  logic [WIDTH-1:0] Duty,
    input  logic             CntDone,
    output logic             CntEnable,
    output logic [WIDTH-1:0] CntMaxCount,
    output logic             PwmOut,
    output logic             PeriodTick,
    output logic             Busy,
    output logic             Clamped
);

    typedef enum logic [2:0] {IDLE, HI_CLR, HI_RUN, LO_CLR, LO_RUN} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] hi_len;
        logic [WIDTH-1:0] lo_len;
        logic             has_hi;
        logic             clamp;
    } phases_t;

    localparam logic [WIDTH-1:0] MIN_LEN = WIDTH'(MIN_PHASE);

    function automatic logic [WIDTH-1:0] stretch(input logic [WIDTH-1:0] len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

    function automatic logic is_short(input logic [WIDTH-1:0] len);
        return (len != '0) && (len < MIN_LEN);
    endfunction

    // A zero-length request is not a clamp; only a nonzero length raised to MIN_LEN is.
    function automatic phases_t calc_phases(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d);
        phases_t r;
        r = '0;
        if (d == '0) begin
            r.lo_len = stretch(p);
            r.clamp  = is_short(p);
        end else if (d >= p) begin
            r.has_hi = 1'b1;
            r.hi_len = stretch(p);
            r.clamp  = is_short(p);
        end else begin
            r.has_hi = 1'b1;
            r.hi_len = stretch(d);
            r.lo_len = stretch(p - d);
            r.clamp  = is_short(d) | is_short(p - d);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shp_q, shp_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             stop_pending_q, stop_pending_d;
    logic             clamped_q, clamped_d;
    logic [WIDTH-1:0] max_count_q, max_count_d;
    logic             pwm_q, pwm_d;
    logic             enable_q, enable_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    phases_t          new_ph;
    logic             cur_has_lo;
    logic [WIDTH-1:0] cur_lo_len;
    logic             period_start;
    logic             period_end;

    // Fresh settings decide the phase plan at a period start; the shadows decide it mid-period.
    assign new_ph     = calc_phases(Period, Duty);
    assign cur_has_lo = (shd_q < shp_q);
    assign cur_lo_len = stretch(shp_q - shd_q);

    always_comb begin
        state_d        = state_q;
        shp_d          = shp_q;
        shd_d          = shd_q;
        stop_pending_d = stop_pending_q;
        clamped_d      = clamped_q;
        max_count_d    = max_count_q;
        tick_d         = 1'b0;
        period_start   = 1'b0;
        period_end     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    period_start   = 1'b1;
                    clamped_d      = 1'b0;
                    stop_pending_d = Stop;
                end
            end
            HI_CLR: state_d = HI_RUN;
            HI_RUN: begin
                if (CntDone) begin
                    if (cur_has_lo) begin
                        state_d     = LO_CLR;
                        max_count_d = cur_lo_len - MIN_LEN;
                    end else begin
                        period_end = 1'b1;
                    end
                end
            end
            LO_CLR: state_d = LO_RUN;
            LO_RUN: begin
                if (CntDone) begin
                    period_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (Stop && (state_q != IDLE)) begin
            stop_pending_d = 1'b1;
        end

        if (period_end) begin
            if (stop_pending_q || Stop) begin
                state_d        = IDLE;
                stop_pending_d = 1'b0;
            end else begin
                period_start = 1'b1;
            end
        end

        if (period_start) begin
            shp_d     = Period;
            shd_d     = Duty;
            tick_d    = 1'b1;
            clamped_d = clamped_d | new_ph.clamp;
            if (new_ph.has_hi) begin
                state_d     = HI_CLR;
                max_count_d = new_ph.hi_len - MIN_LEN;
            end else begin
                state_d     = LO_CLR;
                max_count_d = new_ph.lo_len - MIN_LEN;
            end
        end

        pwm_d    = (state_d == HI_CLR) || (state_d == HI_RUN);
        enable_d = (state_d == HI_RUN) || (state_d == LO_RUN);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge MClk or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            shp_q          <= '0;
            shd_q          <= '0;
            stop_pending_q <= 1'b0;
            clamped_q      <= 1'b0;
            max_count_q    <= '0;
            pwm_q          <= 1'b0;
            enable_q       <= 1'b0;
            tick_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shp_q          <= shp_d;
            shd_q          <= shd_d;
            stop_pending_q <= stop_pending_d;
            clamped_q      <= clamped_d;
            max_count_q    <= max_count_d;
            pwm_q          <= pwm_d;
            enable_q       <= enable_d;
            tick_q         <= tick_d;
            busy_q         <= busy_d;
        end
    end

    assign CntEnable   = enable_q;
    assign CntMaxCount = max_count_q;
    assign PwmOut      = pwm_q;
    assign PeriodTick  = tick_q;
    assign Busy        = busy_q;
    assign Clamped     = clamped_q;

endmodule

// File: tb/tb_pwm_phase_sequencer.sv
// Directed bench for pwm_phase_sequencer with a behavioural Counter closing the Enable/MaxCount/Done loop.
// Waveform expectations are generated from hand-chosen high/low phase lengths per test step.
module tb_pwm_phase_sequencer;

    logic        MClk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stop;
    logic [15:0] Period;
    logic [15:0] Duty;
    logic        CntDone;
    logic        CntEnable;
    logic [15:0] CntMaxCount;
    logic        PwmOut;
    logic        PeriodTick;
    logic        Busy;
    logic        Clamped;

    int checks = 0;
    int errors = 0;

    logic [15:0] cntValue;
    logic        cntDoneQ;

    pwm_phase_sequencer #(.WIDTH(16), .MIN_PHASE(3)) dut (
        .MClk        (MClk),
        .Reset       (Reset),
        .Start       (Start),
        .Stop        (Stop),
        .Period      (Period),
        .Duty        (Duty),
        .CntDone     (CntDone),
        .CntEnable   (CntEnable),
        .CntMaxCount (CntMaxCount),
        .PwmOut      (PwmOut),
        .PeriodTick  (PeriodTick),
        .Busy        (Busy),
        .Clamped     (Clamped)
    );

    always #5 MClk = ~MClk;

    // Downstream Counter: cleared while disabled, Done rises one cycle after count hits MaxCount
    // and stays up (stale) until the next clear cycle.
    always @(posedge MClk or posedge Reset) begin
        if (Reset) begin
            cntValue <= 16'd0;
            cntDoneQ <= 1'b0;
        end else if (!CntEnable) begin
            cntValue <= 16'd0;
            cntDoneQ <= 1'b0;
        end else begin
            cntValue <= cntValue + 16'd1;
            if (cntValue == CntMaxCount) begin
                cntDoneQ <= 1'b1;
            end
        end
    end

    assign CntDone = cntDoneQ;

    // Drives all control/settings inputs in one go.
    task automatic applyStimulus(input logic start, input logic stop,
                                 input logic [15:0] period, input logic [15:0] duty);
        Start  = start;
        Stop   = stop;
        Period = period;
        Duty   = duty;
    endtask

    // One comparison; counts it and reports a failure with tag/observed/expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        assert (observed === 32'(expected)) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks numCycles consecutive cycles of a running waveform with the given phase lengths,
    // starting at phase offset firstCycle; leaves the bench one negedge after the last check.
    task automatic checkPeriodPattern(input int hiLen, input int loLen, input int firstCycle,
                                      input int numCycles, input string tag);
        int period;
        int ph;
        logic clrCycle;
        period = hiLen + loLen;
        for (int i = firstCycle; i < firstCycle + numCycles; i++) begin
            ph = i % period;
            clrCycle = (ph == 0) || (hiLen > 0 && loLen > 0 && ph == hiLen);
            checkOutput($sformatf("%s_pwm@%0d", tag, i), 32'(PwmOut), (ph < hiLen) ? 1 : 0);
            checkOutput($sformatf("%s_tick@%0d", tag, i), 32'(PeriodTick), (ph == 0) ? 1 : 0);
            checkOutput($sformatf("%s_busy@%0d", tag, i), 32'(Busy), 1);
            checkOutput($sformatf("%s_en@%0d", tag, i), 32'(CntEnable), clrCycle ? 0 : 1);
            if (ph == 0) begin
                checkOutput($sformatf("%s_max@%0d", tag, i), 32'(CntMaxCount),
                            (hiLen > 0) ? hiLen - 3 : loLen - 3);
            end else if (clrCycle) begin
                checkOutput($sformatf("%s_max@%0d", tag, i), 32'(CntMaxCount), loLen - 3);
            end
            @(negedge MClk);
        end
    endtask

    // Checks the idle output set (everything low except the sticky Clamped).
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 32'(Busy), 0);
        checkOutput({tag, "_pwm"}, 32'(PwmOut), 0);
        checkOutput({tag, "_en"}, 32'(CntEnable), 0);
        checkOutput({tag, "_tick"}, 32'(PeriodTick), 0);
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
        #3;
        checkIdle("rst");
        checkOutput("rst_max", 32'(CntMaxCount), 0);
        checkOutput("rst_clamped", 32'(Clamped), 0);
        @(negedge MClk);
        Reset = 1'b0;

        // Stop alone while idle must do nothing.
        @(negedge MClk);
        applyStimulus(1'b0, 1'b1, 16'd10, 16'd4);
        @(negedge MClk);
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        @(negedge MClk);
        checkIdle("idle_stop");

        // 10/4: 4 high, 6 low, MaxCount 1 then 3, no clamp.
        applyStimulus(1'b1, 1'b0, 16'd10, 16'd4);
        @(negedge MClk);
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        checkPeriodPattern(4, 6, 0, 20, "t1");
        checkOutput("t1_clamped", 32'(Clamped), 0);

        // Duty change during the high phase only takes effect from the next period.
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd7);
        checkPeriodPattern(4, 6, 0, 10, "t4a");
        checkPeriodPattern(7, 3, 0, 20, "t4b");
        checkOutput("t4_clamped", 32'(Clamped), 0);

        // Stop in the high phase: the 10/4 period finishes, then idle.
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        checkPeriodPattern(7, 3, 0, 10, "t5a");
        checkPeriodPattern(4, 6, 0, 1, "t5b");
        applyStimulus(1'b0, 1'b1, 16'd10, 16'd4);
        checkPeriodPattern(4, 6, 1, 1, "t5b");
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        checkPeriodPattern(4, 6, 2, 8, "t5b");
        checkIdle("t5_end");
        repeat (3) @(negedge MClk);
        checkIdle("t5_hold");

        // 10/1: high stretched to 3 -> 3/9, Clamped sticks after Duty=5.
        applyStimulus(1'b1, 1'b0, 16'd10, 16'd1);
        @(negedge MClk);
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd1);
        checkPeriodPattern(3, 9, 0, 24, "t3a");
        checkOutput("t3_clamped_set", 32'(Clamped), 1);
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd5);
        checkPeriodPattern(3, 9, 0, 12, "t3b");
        checkPeriodPattern(5, 5, 0, 10, "t3c");
        checkOutput("t3_clamped_sticky", 32'(Clamped), 1);

        // 8/0 low-only, then 8/8 high-only.
        applyStimulus(1'b0, 1'b0, 16'd8, 16'd0);
        checkPeriodPattern(5, 5, 0, 10, "t2pre");
        checkPeriodPattern(0, 8, 0, 16, "t2a");
        applyStimulus(1'b0, 1'b0, 16'd8, 16'd8);
        checkPeriodPattern(0, 8, 0, 8, "t2a");
        checkPeriodPattern(8, 0, 0, 16, "t2b");

        // Reset mid LO_RUN clears outputs before the next clock edge.
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        checkPeriodPattern(8, 0, 0, 8, "t6pre");
        checkPeriodPattern(4, 6, 0, 6, "t6run");
        #2;
        Reset = 1'b1;
        #1;
        checkIdle("t6_async");
        checkOutput("t6_async_max", 32'(CntMaxCount), 0);
        checkOutput("t6_async_clamped", 32'(Clamped), 0);
        @(negedge MClk);
        Reset = 1'b0;
        repeat (3) @(negedge MClk);
        checkIdle("t6_after");

        // Start and Stop together from idle: exactly one period, then idle.
        applyStimulus(1'b1, 1'b1, 16'd10, 16'd4);
        @(negedge MClk);
        applyStimulus(1'b0, 1'b0, 16'd10, 16'd4);
        checkPeriodPattern(4, 6, 0, 10, "t7");
        checkIdle("t7_end");
        checkOutput("t7_clamped", 32'(Clamped), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
